// File: rtl/serial_word_receiver.sv
// -----------------------------------------------------------------------------
// serial_word_receiver
//
// Receiving end of a param_shift_register serial link. Bits are sampled from
// the shiftout stream on cycles where enable is high. A word starts on a bit
// that is sampled with frame high. Once SHIFT_WIDTH bits have arrived, the word
// is handed to a one-word output buffer that a parallel consumer drains with a
// valid/ready handshake.
//
// Parameters
//   SHIFT_WIDTH     word width in bits (>= 2)
//   SHIFT_DIRECTION "LEFT"  : transmitter sends MSB first
//                   "RIGHT" : transmitter sends LSB first
//   CLEAR_VALUE     value loaded into q and the shift register on reset / sclr
//
// Ports
//   clock      rising-edge clock
//   aclr_n     asynchronous active-low reset
//   sclr       synchronous clear, overrides every other synchronous input
//   enable     bit strobe; shiftin and frame are sampled only while high
//   shiftin    serial data bit
//   frame      start-of-word marker, sampled together with the first bit
//   q_ready    consumer accepts q
//   q          received word
//   q_valid    q holds a word that has not been consumed yet
//   busy       a word is partially received
//   bit_count  number of bits captured in the current word
//   overrun    sticky: a completed word was dropped because the buffer was full
//   frame_err  sticky: frame arrived before the current word was complete
// -----------------------------------------------------------------------------
module serial_word_receiver #(
    parameter int                     SHIFT_WIDTH     = 8,
    parameter string                  SHIFT_DIRECTION = "LEFT",
    parameter logic [SHIFT_WIDTH-1:0] CLEAR_VALUE     = '0
) (
    input  logic                               clock,
    input  logic                               aclr_n,
    input  logic                               sclr,
    input  logic                               enable,
    input  logic                               shiftin,
    input  logic                               frame,
    input  logic                               q_ready,
    output logic [SHIFT_WIDTH-1:0]             q,
    output logic                               q_valid,
    output logic                               busy,
    output logic [$clog2(SHIFT_WIDTH+1)-1:0]   bit_count,
    output logic                               overrun,
    output logic                               frame_err
);

    localparam int CNT_W   = $clog2(SHIFT_WIDTH + 1);
    localparam bit IS_LEFT = (SHIFT_DIRECTION == "LEFT");

    // Count value seen just before the capture that completes a word.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHIFT_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [SHIFT_WIDTH-1:0]  sr;
    logic [SHIFT_WIDTH-1:0]  sr_nxt;
    logic [SHIFT_WIDTH-1:0]  sr_shifted;
    logic [CNT_W-1:0]        bit_count_nxt;
    logic [SHIFT_WIDTH-1:0]  q_nxt;
    logic                    q_valid_nxt;
    logic                    overrun_nxt;
    logic                    frame_err_nxt;
    logic                    word_done;

    // The shift register with the current shiftin bit folded in. This is
    // also the finished word on the completing edge, so the output buffer
    // loads it directly and q_valid rises on the same edge as the last bit.
    generate
        if (IS_LEFT) begin : g_msb_first
            assign sr_shifted = {sr[SHIFT_WIDTH-2:0], shiftin};
        end else begin : g_lsb_first
            assign sr_shifted = {shiftin, sr[SHIFT_WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register and all registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state     <= IDLE;
            sr        <= CLEAR_VALUE;
            bit_count <= '0;
            q         <= CLEAR_VALUE;
            q_valid   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else if (sclr) begin
            state     <= IDLE;
            sr        <= CLEAR_VALUE;
            bit_count <= '0;
            q         <= CLEAR_VALUE;
            q_valid   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            sr        <= sr_nxt;
            bit_count <= bit_count_nxt;
            q         <= q_nxt;
            q_valid   <= q_valid_nxt;
            overrun   <= overrun_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Word assembly: next state, shift register and bit counter
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        sr_nxt        = sr;
        bit_count_nxt = bit_count;
        word_done     = 1'b0;
        frame_err_nxt = frame_err;

        if (enable) begin
            unique case (state)
                IDLE: begin
                    // Bits outside a frame are ignored.
                    if (frame) begin
                        sr_nxt        = sr_shifted;
                        bit_count_nxt = CNT_W'(1);
                        state_nxt     = SHIFT;
                    end
                end
                SHIFT: begin
                    sr_nxt = sr_shifted;
                    if (frame) begin
                        // Early frame: the partial word is abandoned and this
                        // bit becomes the first bit of a new word.
                        bit_count_nxt = CNT_W'(1);
                        frame_err_nxt = 1'b1;
                    end else if (bit_count == LAST_CNT) begin
                        bit_count_nxt = '0;
                        state_nxt     = IDLE;
                        word_done     = 1'b1;
                    end else begin
                        bit_count_nxt = bit_count + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // One-word output buffer with valid/ready handshake
    // ------------------------------------------------------------------
    always_comb begin
        q_nxt       = q;
        q_valid_nxt = q_valid;
        overrun_nxt = overrun;

        if (word_done) begin
            // A consumer taking the held word on this same edge frees the
            // slot, so back-to-back words need no idle cycle.
            if (!q_valid || q_ready) begin
                q_nxt       = sr_shifted;
                q_valid_nxt = 1'b1;
            end else begin
                overrun_nxt = 1'b1;
            end
        end else if (q_valid && q_ready) begin
            q_valid_nxt = 1'b0;
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_serial_word_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_word_receiver
//
// Drives one MSB-first and one LSB-first receiver from the same serial stream.
// A behavioural model tracks the received bits as a plain array and builds the
// expected words arithmetically when a word completes. Every cycle, both
// receivers are compared against the model. Directed sequences add literal
// expectations, followed by a long randomized run.
// -----------------------------------------------------------------------------
module tb_serial_word_receiver;

    localparam int W = 8;

    logic       clock;
    logic       aclr_n;
    logic       sclr;
    logic       enable;
    logic       shiftin;
    logic       frame;
    logic       q_ready;

    logic [W-1:0] l_q, r_q;
    logic         l_q_valid, r_q_valid;
    logic         l_busy, r_busy;
    logic [3:0]   l_bit_count, r_bit_count;
    logic         l_overrun, r_overrun;
    logic         l_frame_err, r_frame_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    serial_word_receiver #(
        .SHIFT_WIDTH    (W),
        .SHIFT_DIRECTION("LEFT"),
        .CLEAR_VALUE    ('0)
    ) u_left (
        .clock    (clock),
        .aclr_n   (aclr_n),
        .sclr     (sclr),
        .enable   (enable),
        .shiftin  (shiftin),
        .frame    (frame),
        .q_ready  (q_ready),
        .q        (l_q),
        .q_valid  (l_q_valid),
        .busy     (l_busy),
        .bit_count(l_bit_count),
        .overrun  (l_overrun),
        .frame_err(l_frame_err)
    );

    serial_word_receiver #(
        .SHIFT_WIDTH    (W),
        .SHIFT_DIRECTION("RIGHT"),
        .CLEAR_VALUE    ('0)
    ) u_right (
        .clock    (clock),
        .aclr_n   (aclr_n),
        .sclr     (sclr),
        .enable   (enable),
        .shiftin  (shiftin),
        .frame    (frame),
        .q_ready  (q_ready),
        .q        (r_q),
        .q_valid  (r_q_valid),
        .busy     (r_busy),
        .bit_count(r_bit_count),
        .overrun  (r_overrun),
        .frame_err(r_frame_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_in_word = 1'b0;
    int         m_n       = 0;
    bit         m_bits [0:W-1];
    logic [W-1:0] m_q_l   = '0;
    logic [W-1:0] m_q_r   = '0;
    bit         m_qv      = 1'b0;
    bit         m_ovr     = 1'b0;
    bit         m_ferr    = 1'b0;
    bit         m_done;
    logic [W-1:0] m_wl, m_wr;

    task automatic model_reset();
        m_in_word = 1'b0;
        m_n       = 0;
        m_q_l     = '0;
        m_q_r     = '0;
        m_qv      = 1'b0;
        m_ovr     = 1'b0;
        m_ferr    = 1'b0;
    endtask

    always @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            model_reset();
        end else begin
            if (sclr) begin
                model_reset();
            end else begin
                m_done = 1'b0;
                if (enable) begin
                    if (frame) begin
                        if (m_in_word) m_ferr = 1'b1;
                        m_in_word = 1'b1;
                        m_bits[0] = shiftin;
                        m_n       = 1;
                    end else if (m_in_word) begin
                        m_bits[m_n] = shiftin;
                        m_n = m_n + 1;
                        if (m_n == W) begin
                            m_done    = 1'b1;
                            m_in_word = 1'b0;
                            m_n       = 0;
                        end
                    end
                end
                if (m_done) begin
                    // i-th received bit: MSB-first puts it at W-1-i, LSB-first at i.
                    m_wl = '0;
                    m_wr = '0;
                    for (int i = 0; i < W; i++) begin
                        m_wl = m_wl + (W'(m_bits[i]) << (W - 1 - i));
                        m_wr = m_wr + (W'(m_bits[i]) << i);
                    end
                    if (!m_qv || q_ready) begin
                        m_q_l = m_wl;
                        m_q_r = m_wr;
                        m_qv  = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else if (m_qv && q_ready) begin
                    m_qv = 1'b0;
                end
            end
            #1;
            if (chk_en) begin
                chk("l_q", l_q, m_q_l);
                chk("r_q", r_q, m_q_r);
                chk("l_q_valid", l_q_valid, m_qv);
                chk("r_q_valid", r_q_valid, m_qv);
                chk("l_busy", l_busy, m_in_word);
                chk("r_busy", r_busy, m_in_word);
                chk("l_bit_count", l_bit_count, m_n);
                chk("r_bit_count", r_bit_count, m_n);
                chk("l_overrun", l_overrun, m_ovr);
                chk("r_overrun", r_overrun, m_ovr);
                chk("l_frame_err", l_frame_err, m_ferr);
                chk("r_frame_err", r_frame_err, m_ferr);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_bit(input bit f, input bit b, input bit en);
        @(negedge clock);
        frame   = f;
        shiftin = b;
        enable  = en;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) send_bit(i == 0, w[W-1-i], 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0, 1'b0);
    endtask

    task automatic after_edge();
        @(posedge clock);
        #2;
    endtask

    task automatic pulse_sclr();
        @(negedge clock);
        enable = 1'b0;
        frame  = 1'b0;
        sclr   = 1'b1;
        after_edge();
        chk("sclr_overrun", l_overrun, 0);
        chk("sclr_q_valid", l_q_valid, 0);
        chk("sclr_frame_err", r_frame_err, 0);
        @(negedge clock);
        sclr = 1'b0;
    endtask

    initial begin
        aclr_n  = 1'b0;
        sclr    = 1'b0;
        enable  = 1'b0;
        frame   = 1'b0;
        shiftin = 1'b0;
        q_ready = 1'b1;
        #12;
        chk("rst_q", l_q, 0);
        chk("rst_q_valid", l_q_valid, 0);
        chk("rst_busy", r_busy, 0);
        chk("rst_bit_count", l_bit_count, 0);
        chk("rst_overrun", r_overrun, 0);
        chk("rst_frame_err", l_frame_err, 0);
        @(negedge clock);
        aclr_n = 1'b1;
        chk_en = 1'b1;

        // Basic word, consumer always ready; 11011011 is the same either direction.
        send_word(8'hDB);
        after_edge();
        chk("dir_left_q", l_q, 8'hDB);
        chk("dir_right_q", r_q, 8'hDB);
        chk("done_q_valid", l_q_valid, 1);
        chk("done_bit_count", l_bit_count, 0);
        idle(1);
        after_edge();
        chk("one_cycle_q_valid", l_q_valid, 0);
        chk("hold_q", l_q, 8'hDB);

        // Back-to-back words with the consumer stalled.
        q_ready = 1'b0;
        send_word(8'hA5);
        send_word(8'h3C);
        after_edge();
        chk("stall_q", l_q, 8'hA5);
        chk("stall_q_valid", l_q_valid, 1);
        chk("stall_overrun", l_overrun, 1);
        @(negedge clock);
        q_ready = 1'b1;
        enable  = 1'b0;
        after_edge();
        chk("drain_q_valid", l_q_valid, 0);
        chk("drain_q", l_q, 8'hA5);
        chk("sticky_overrun", r_overrun, 1);
        pulse_sclr();

        // Resync: three bits of an abandoned word, then a full word.
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b0, 1'b1, 1'b1);
        send_word(8'h0F);
        after_edge();
        chk("resync_frame_err", l_frame_err, 1);
        chk("resync_left_q", l_q, 8'h0F);
        chk("resync_right_q", r_q, 8'hF0);
        chk("resync_overrun", l_overrun, 0);
        pulse_sclr();

        // Enable gaps between every bit, with shiftin toggling while disabled.
        for (int i = 0; i < W; i++) begin
            if (i != 0) send_bit(1'b0, ~shiftin, 1'b0);
            send_bit(i == 0, (8'h81 >> (W - 1 - i)) & 1, 1'b1);
        end
        after_edge();
        chk("gaps_left_q", l_q, 8'h81);
        chk("gaps_right_q", r_q, 8'h81);

        // Asynchronous reset in the middle of a word.
        for (int i = 0; i < 4; i++) send_bit(i == 0, 1'b1, 1'b1);
        @(posedge clock);
        #3;
        aclr_n = 1'b0;
        #1;
        chk("areset_q", l_q, 0);
        chk("areset_q_valid", r_q_valid, 0);
        chk("areset_busy", l_busy, 0);
        chk("areset_bit_count", r_bit_count, 0);
        @(negedge clock);
        enable = 1'b0;
        aclr_n = 1'b1;
        send_word(8'hC3);
        after_edge();
        chk("post_reset_q", l_q, 8'hC3);
        chk("post_reset_right_q", r_q, 8'hC3);
        chk("post_reset_frame_err", l_frame_err, 0);
        chk("post_reset_overrun", l_overrun, 0);

        // Overrun then synchronous clear.
        q_ready = 1'b0;
        send_word(8'h5A);
        after_edge();
        chk("overrun_set", l_overrun, 1);
        chk("overrun_q_kept", l_q, 8'hC3);
        pulse_sclr();
        q_ready = 1'b1;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            enable  = ($urandom % 10) < 7;
            frame   = ($urandom % 8) == 0;
            shiftin = $urandom % 2;
            q_ready = $urandom % 2;
            sclr    = ($urandom % 150) == 0;
        end
        @(negedge clock);
        sclr   = 1'b0;
        enable = 1'b0;
        idle(3);
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Serial-in, parallel-out receiver. It is the far end of the param_shift_register serial link.
- Samples the shiftout stream and rebuilds SHIFT_WIDTH-bit words. Bit order follows SHIFT_DIRECTION.
- Each finished word is presented on q with a valid/ready handshake, backed by a one-word output buffer.
- Sits between the serial link and any parallel consumer. Lost words and framing errors are reported through sticky flags.

Parameters:
- SHIFT_WIDTH, 8, word width in bits. Must be >= 2.
- SHIFT_DIRECTION, "LEFT", transmitter shift direction. "LEFT" means MSB first; "RIGHT" means LSB first.
- CLEAR_VALUE, 0, value loaded into q and the shift register by sclr and by reset.

Ports:
- clock, input, 1, single rising-edge clock.
- aclr_n, input, 1, asynchronous active-low reset.
- sclr, input, 1, synchronous clear. Highest synchronous priority.
- enable, input, 1, bit strobe. shiftin and frame are sampled only when enable=1.
- shiftin, input, 1, serial data bit.
- frame, input, 1, start-of-word marker. Asserted together with the first bit of a word.
- q_ready, input, 1, consumer accepts q.
- q, output, SHIFT_WIDTH, received word.
- q_valid, output, 1, q holds an unconsumed word.
- busy, output, 1, a word is partially received (state SHIFT).
- bit_count, output, clog2(SHIFT_WIDTH+1), number of bits captured in the current word.
- overrun, output, 1, sticky. A completed word was dropped because the buffer was full.
- frame_err, output, 1, sticky. frame arrived before the current word was complete.

Behaviour:
- Reset (aclr_n=0, asynchronous):
  - state=IDLE, shift register=CLEAR_VALUE, q=CLEAR_VALUE, bit_count=0.
  - q_valid=0, busy=0, overrun=0, frame_err=0.
  - Reset mid-word discards the partial word with no flag.
- sclr=1 at a clock edge has the same effect as reset, synchronously. It overrides enable, frame and q_ready.
- Bit capture on enable=1:
  - LEFT: sr <= {sr[W-2:0], shiftin}.
  - RIGHT: sr <= {shiftin, sr[W-1:1]}.
- enable=0: no sampling. State, bit_count and sr hold. The q handshake still operates.
- State IDLE:
  - enable=1 & frame=1: capture bit, bit_count=1, go to SHIFT.
  - enable=1 & frame=0: bit ignored, stay in IDLE.
- State SHIFT:
  - enable=1 & frame=0: capture bit, bit_count+1.
  - enable=1 & frame=1: restart the word. Capture the bit as the first bit, bit_count=1, set frame_err, discard the partial word.
  - Word complete: the capture makes bit_count reach SHIFT_WIDTH. On that same edge:
    - go to IDLE with bit_count=0;
    - the assembled word (including the current bit) is offered to the output buffer.
- Output buffer:
  - Accepted when q_valid=0, or when q_valid=1 & q_ready=1 on the same edge. Then q <= word and q_valid=1.
  - Otherwise the word is dropped, overrun is set, and q/q_valid are unchanged.
  - q_valid=1 & q_ready=1 with no new word: q_valid <= 0. q holds its last value.
- q is stable while q_valid=1 and q_ready=0.
- Latency: q_valid rises on the same edge that samples the last bit. Back-to-back words therefore need no idle cycle.
- busy = (state==SHIFT). bit_count and busy are registered outputs.
- overrun and frame_err clear only on reset or sclr.
- Width rules: bit_count is never greater than SHIFT_WIDTH. It never exceeds SHIFT_WIDTH-1 after an edge, because it returns to 0 on completion.

Test Plan:
- LEFT, W=8, q_ready=1:
  - stimulus: frame+bit pattern 1,1,0,1,1,0,1,1, with enable=1 every cycle;
  - response: q=8'b11011011, q_valid=1 for exactly 1 cycle after the 8th edge, bit_count sequence 1..7 then 0.
- Back-to-back, q_ready=0:
  - stimulus: send 8'hA5, then 8'h3C immediately after;
  - response: q stays 8'hA5 with q_valid=1, and overrun=1 after the second word completes.
  - then raise q_ready: q_valid drops next edge, q remains 8'hA5.
- Resync:
  - stimulus: frame, 3 bits, then frame again, followed by 8 bits of 8'h0F;
  - response: frame_err=1, q=8'h0F, no overrun.
- enable gaps:
  - stimulus: send 8'h81 with enable=0 between every bit (shiftin toggled while disabled);
  - response: q=8'h81, bit_count holds during the gaps.
- Reset and clear:
  - stimulus: aclr_n pulsed low mid-clock after 4 bits;
  - response: all outputs 0 immediately. Then send 8'hC3: q=8'hC3 with no flags. sclr with overrun=1 clears overrun and q_valid on the next edge.
- RIGHT, W=8:
  - stimulus: transmit LSB first, i.e. bits 1,1,0,1,1,0,1,1 for 8'hDB;
  - response: q=8'b11011011.
